// File: rtl/bicubic_scheduler_if.sv
// Bundle of every non-clock signal of the bicubic scheduler:
//   request channel  : req_valid/req_ready, req_x, req_y, req_fx, req_fy
//   image read port  : rd_en, rd_addr (= {yc, xc}), rd_data (1-cycle read latency)
//   cubic engine port: eng_x ({t, t^2, t^3}), eng_p, eng_cnt, eng_out
//   result channel   : res_valid/res_ready, res_data
// The master modport is the scheduler's view; slave is the surrounding
// system (request source, image RAM, engine, result consumer).
interface bicubic_scheduler_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [XW-1:0]     req_x;
  logic [YW-1:0]     req_y;
  logic [7:0]        req_fx;
  logic [7:0]        req_fy;

  logic              rd_en;
  logic [XW+YW-1:0]  rd_addr;
  logic [7:0]        rd_data;

  logic [23:0]       eng_x;
  logic [7:0]        eng_p;
  logic [2:0]        eng_cnt;
  logic [7:0]        eng_out;

  logic              res_valid;
  logic [7:0]        res_data;
  logic              res_ready;

  modport master (
    input  req_valid, req_x, req_y, req_fx, req_fy,
    output req_ready,
    output rd_en, rd_addr,
    input  rd_data,
    output eng_x, eng_p, eng_cnt,
    input  eng_out,
    output res_valid, res_data,
    input  res_ready
  );

  modport slave (
    output req_valid, req_x, req_y, req_fx, req_fy,
    input  req_ready,
    input  rd_en, rd_addr,
    output rd_data,
    input  eng_x, eng_p, eng_cnt,
    output eng_out,
    input  res_valid, res_data,
    output res_ready
  );
endinterface

// File: rtl/bicubic_scheduler.sv
// Bicubic scheduler: turns one interpolation request into one output pixel by
// driving the shared 5-cycle cubic engine. For each request it reads the
// clamped 4x4 neighbourhood around (x, y), runs four horizontal passes with
// fx (one per row), then one vertical pass with fy over the row results.
// Fixed latency: res_valid rises 28 cycles after the accepting cycle.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset (aborts any request in flight)
//   bus  - bicubic_scheduler_if.master (request, image read, engine, result)
module bicubic_scheduler #(
  parameter int XW = 5,
  parameter int YW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  bicubic_scheduler_if.master   bus
);

  typedef enum logic [2:0] {IDLE, PRIME, HPASS, VPASS, FLUSH, CAPT, DONE} state_t;

  state_t            state_reg;
  logic [XW-1:0]     x_reg;
  logic [YW-1:0]     y_reg;
  logic [7:0]        fy_reg, fy2_reg, fy3_reg;
  logic [1:0]        row_reg;
  logic [2:0]        step_reg;     // engine step of the current cycle, 0 = seam
  logic [7:0]        hbuf [4];     // horizontal pass results, one per row

  logic              rd_en_reg;
  logic [XW+YW-1:0]  rd_addr_reg;
  logic [23:0]       eng_x_reg;
  logic [2:0]        eng_cnt_reg;
  logic              res_valid_reg;
  logic [7:0]        res_data_reg;
  logic [7:0]        eng_p_next;

  logic [7:0]        fx2_c, fx3_c, fy2_c, fy3_c;

  // Rounded Q0.8 product: (a*b + 128) >> 8.
  function automatic logic [7:0] mul_q8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b) + 16'd128;
    return prod[15:8];
  endfunction

  // idx 0..3 selects offset -1..+2. Two guard bits: the top bit is the sign
  // (below 0) and the next one flags overflow past the last column.
  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] base, input logic [1:0] idx);
    logic [XW+1:0] s;
    s = {2'b00, base} + {{XW{1'b0}}, idx} - {{(XW+1){1'b0}}, 1'b1};
    if (s[XW+1])  return '0;
    else if (s[XW]) return '1;
    else          return s[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] base, input logic [1:0] idx);
    logic [YW+1:0] s;
    s = {2'b00, base} + {{YW{1'b0}}, idx} - {{(YW+1){1'b0}}, 1'b1};
    if (s[YW+1])  return '0;
    else if (s[YW]) return '1;
    else          return s[YW-1:0];
  endfunction

  // Powers are computed straight from the request inputs so eng_x already
  // holds {fx, fx^2, fx^3} in the PRIME cycle.
  assign fx2_c = mul_q8(bus.req_fx, bus.req_fx);
  assign fx3_c = mul_q8(fx2_c, bus.req_fx);
  assign fy2_c = mul_q8(bus.req_fy, bus.req_fy);
  assign fy3_c = mul_q8(fy2_c, bus.req_fy);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      fy_reg        <= '0;
      fy2_reg       <= '0;
      fy3_reg       <= '0;
      row_reg       <= '0;
      step_reg      <= '0;
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      eng_x_reg     <= '0;
      eng_cnt_reg   <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          rd_en_reg   <= 1'b0;
          eng_cnt_reg <= 3'd0;
          if (bus.req_valid) begin
            x_reg       <= bus.req_x;
            y_reg       <= bus.req_y;
            fy_reg      <= bus.req_fy;
            fy2_reg     <= fy2_c;
            fy3_reg     <= fy3_c;
            eng_x_reg   <= {bus.req_fx, fx2_c, fx3_c};
            // PRIME issues the read for row 0, step 1.
            rd_en_reg   <= 1'b1;
            rd_addr_reg <= {clamp_y(bus.req_y, 2'd0), clamp_x(bus.req_x, 2'd0)};
            row_reg     <= 2'd0;
            state_reg   <= PRIME;
          end
        end
        PRIME: begin
          eng_cnt_reg <= 3'd1;
          step_reg    <= 3'd1;
          rd_en_reg   <= 1'b1;
          rd_addr_reg <= {clamp_y(y_reg, row_reg), clamp_x(x_reg, 2'd1)};
          state_reg   <= HPASS;
        end
        HPASS: begin
          // The previous row's result shows up the cycle after its seam.
          if (step_reg == 3'd1 && row_reg != 2'd0)
            hbuf[row_reg - 2'd1] <= bus.eng_out;
          case (step_reg)
            3'd1, 3'd2: begin
              eng_cnt_reg <= step_reg + 3'd1;
              step_reg    <= step_reg + 3'd1;
              rd_en_reg   <= 1'b1;
              rd_addr_reg <= {clamp_y(y_reg, row_reg), clamp_x(x_reg, step_reg[1:0] + 2'd1)};
            end
            3'd3: begin
              eng_cnt_reg <= 3'd4;
              step_reg    <= 3'd4;
              rd_en_reg   <= 1'b0;
            end
            3'd4: begin
              eng_cnt_reg <= 3'd0;
              step_reg    <= 3'd0;
              rd_en_reg   <= (row_reg != 2'd3);
              rd_addr_reg <= {clamp_y(y_reg, row_reg + 2'd1), clamp_x(x_reg, 2'd0)};
              // The engine samples X on the last seam for the vertical pass.
              if (row_reg == 2'd3)
                eng_x_reg <= {fy_reg, fy2_reg, fy3_reg};
            end
            default: begin
              eng_cnt_reg <= 3'd1;
              step_reg    <= 3'd1;
              if (row_reg == 2'd3) begin
                rd_en_reg <= 1'b0;
                state_reg <= VPASS;
              end else begin
                row_reg     <= row_reg + 2'd1;
                rd_en_reg   <= 1'b1;
                rd_addr_reg <= {clamp_y(y_reg, row_reg + 2'd1), clamp_x(x_reg, 2'd1)};
              end
            end
          endcase
        end
        VPASS: begin
          // Row 3 lands now; it is not consumed until step 4.
          if (step_reg == 3'd1)
            hbuf[3] <= bus.eng_out;
          if (step_reg == 3'd4) begin
            eng_cnt_reg <= 3'd0;
            step_reg    <= 3'd0;
            state_reg   <= FLUSH;
          end else begin
            eng_cnt_reg <= step_reg + 3'd1;
            step_reg    <= step_reg + 3'd1;
          end
        end
        FLUSH: begin
          eng_cnt_reg <= 3'd0;
          state_reg   <= CAPT;
        end
        CAPT: begin
          res_data_reg  <= bus.eng_out;
          res_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Pixel data reaches the engine in the same cycle rd_data is valid, so the
  // P input is a mux rather than a register.
  always_comb begin
    eng_p_next = 8'd0;
    if (state_reg == HPASS && step_reg != 3'd0)
      eng_p_next = bus.rd_data;
    else if (state_reg == VPASS)
      eng_p_next = hbuf[step_reg[1:0] - 2'd1];
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rd_en     = rd_en_reg;
  assign bus.rd_addr   = rd_addr_reg;
  assign bus.eng_x     = eng_x_reg;
  assign bus.eng_cnt   = eng_cnt_reg;
  assign bus.eng_p     = eng_p_next;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;

endmodule

// File: tb/tb_bicubic_scheduler.sv
// Bench for bicubic_scheduler: image RAM model, behavioural cubic engine and
// a reference model that computes the expected neighbourhood, row results
// and output pixel from coordinates and fractions.
module tb_bicubic_scheduler;
  localparam int XW = 5;
  localparam int YW = 5;
  localparam int W  = 1 << XW;
  localparam int H  = 1 << YW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bicubic_scheduler_if #(.XW(XW), .YW(YW)) bus ();
  bicubic_scheduler #(.XW(XW), .YW(YW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [7:0] img [0:W*H-1];

  // Image RAM: data valid one cycle after rd_en, zero otherwise.
  always @(posedge clk) bus.rd_data <= bus.rd_en ? img[bus.rd_addr] : 8'h00;

  // Engine arithmetic (behavioural): unity gain of 255/256 on P(0), blended
  // toward P(1) by t, with a t^2/t^3 term on the outer taps.
  function automatic logic [7:0] eng_fn(input int pm, input int p0, input int p1,
                                        input int p2, input logic [23:0] xv);
    int t, t2, t3, acc;
    t  = int'(xv[23:16]);
    t2 = int'(xv[15:8]);
    t3 = int'(xv[7:0]);
    acc = (255 - t) * p0 + t * p1 + ((t2 - t3) * (p2 - pm)) / 4;
    acc = acc >>> 8;
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return 8'(acc);
  endfunction

  // Engine timing model: P on cnt 1..4, X sampled on cnt 0, result the
  // cycle after the seam that closes a 4-step pass.
  logic [7:0]  eng_pb [4];
  logic        eng_full;
  logic [23:0] eng_xl;
  always @(posedge clk) begin
    if (rst) begin
      eng_full    <= 1'b0;
      eng_xl      <= '0;
      bus.eng_out <= '0;
    end else if (bus.eng_cnt >= 3'd1 && bus.eng_cnt <= 3'd4) begin
      eng_pb[bus.eng_cnt - 3'd1] <= bus.eng_p;
      if (bus.eng_cnt == 3'd4) eng_full <= 1'b1;
    end else if (bus.eng_cnt == 3'd0) begin
      if (eng_full)
        bus.eng_out <= eng_fn(int'(eng_pb[0]), int'(eng_pb[1]), int'(eng_pb[2]),
                              int'(eng_pb[3]), eng_xl);
      eng_full <= 1'b0;
      eng_xl   <= bus.eng_x;
    end
  end

  // Reference model
  int         exp_addr [16];
  int         exp_pix  [16];
  int         exp_row  [4];
  int         exp_res;
  int         exp_xf, exp_xv;

  function automatic int pw2(input int t); return (t * t + 128) >> 8; endfunction
  function automatic int pw3(input int t); return (pw2(t) * t + 128) >> 8; endfunction
  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic build_model(input int x, input int y, input int fx, input int fy);
    exp_xf = (fx << 16) | (pw2(fx) << 8) | pw3(fx);
    exp_xv = (fy << 16) | (pw2(fy) << 8) | pw3(fy);
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 4; d++) begin
        exp_addr[r*4+d] = clampi(y + r - 1, H - 1) * W + clampi(x + d - 1, W - 1);
        exp_pix[r*4+d]  = int'(img[exp_addr[r*4+d]]);
      end
      exp_row[r] = int'(eng_fn(exp_pix[r*4], exp_pix[r*4+1], exp_pix[r*4+2],
                               exp_pix[r*4+3], 24'(exp_xf)));
    end
    exp_res = int'(eng_fn(exp_row[0], exp_row[1], exp_row[2], exp_row[3], 24'(exp_xv)));
  endtask

  // Per-cycle trace of one request, index = cycles after the accept cycle.
  logic [2:0]  cnt_log  [0:28];
  logic        en_log   [0:28];
  logic [9:0]  addr_log [0:28];
  logic [23:0] x_log    [0:28];
  logic [7:0]  p_log    [0:28];
  logic        v_log    [0:28];
  int          rd_q [$];

  task automatic fill_random();
    for (int i = 0; i < W*H; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < W*H; i++) img[i] = 8'(v);
  endtask

  task automatic run_request(input int x, input int y, input int fx, input int fy,
                             input int stall, input int abort_at, output int waited);
    int exp_cnt [$];
    int pi;
    build_model(x, y, fx, fy);
    rd_q.delete();
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout got %b want 1", bus.req_ready);
      return;
    end
    bus.req_x = XW'(x); bus.req_y = YW'(y);
    bus.req_fx = 8'(fx); bus.req_fy = 8'(fy);
    bus.req_valid = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      cnt_log[c] = bus.eng_cnt;  en_log[c] = bus.rd_en;  addr_log[c] = bus.rd_addr;
      x_log[c]   = bus.eng_x;    p_log[c]  = bus.eng_p;  v_log[c]    = bus.res_valid;
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rd_en !== 1'b0 || bus.eng_cnt !== 3'd0 ||
            bus.res_valid !== 1'b0) begin
          errors++;
          $display("FAIL abort_idle got ready=%b rd_en=%b cnt=%0d valid=%b want 1 0 0 0",
                   bus.req_ready, bus.rd_en, bus.eng_cnt, bus.res_valid);
        end
        return;
      end
    end
    $display("req x=%0d y=%0d fx=%0d fy=%0d -> res=%0d (model %0d)",
             x, y, fx, fy, bus.res_data, exp_res);
    // Engine step sequence: prime seam, five passes, then capture.
    exp_cnt.push_back(0);
    for (int p = 0; p < 5; p++) begin
      for (int s = 1; s <= 4; s++) exp_cnt.push_back(s);
      exp_cnt.push_back(0);
    end
    exp_cnt.push_back(0);
    for (int c = 1; c <= 27; c++) begin
      checks++;
      if (int'(cnt_log[c]) != exp_cnt[c-1]) begin
        errors++;
        $display("FAIL eng_cnt c=%0d got %0d want %0d", c, cnt_log[c], exp_cnt[c-1]);
      end
      // Reads occupy four of every five cycles until the last seam.
      checks++;
      if (en_log[c] !== ((c <= 20) && ((c - 1) % 5 != 4))) begin
        errors++;
        $display("FAIL rd_en c=%0d got %b", c, en_log[c]);
      end
      checks++;
      if (int'(x_log[c]) != ((c <= 20) ? exp_xf : exp_xv)) begin
        errors++;
        $display("FAIL eng_x c=%0d got %h want %h", c, x_log[c],
                 (c <= 20) ? exp_xf : exp_xv);
      end
      checks++;
      if (v_log[c] !== 1'b0) begin
        errors++;
        $display("FAIL res_valid_early c=%0d got %b want 0", c, v_log[c]);
      end
      if (en_log[c] === 1'b1) rd_q.push_back(int'(addr_log[c]));
    end
    checks++;
    if (rd_q.size() != 16) begin
      errors++;
      $display("FAIL read_count got %0d want 16", rd_q.size());
    end
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] != exp_addr[i]) begin
        errors++;
        $display("FAIL rd_addr #%0d got %0d want %0d", i, rd_q[i], exp_addr[i]);
      end
    end
    pi = 0;
    for (int c = 2; c <= 21; c++) begin
      if (cnt_log[c] != 3'd0 && pi < 16) begin
        checks++;
        if (int'(p_log[c]) != exp_pix[pi]) begin
          errors++;
          $display("FAIL eng_p_h #%0d got %0d want %0d", pi, p_log[c], exp_pix[pi]);
        end
        pi++;
      end
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (int'(p_log[22+r]) != exp_row[r]) begin
        errors++;
        $display("FAIL eng_p_v row%0d got %0d want %0d", r, p_log[22+r], exp_row[r]);
      end
    end
    checks++;
    if (v_log[28] !== 1'b1 || int'(bus.res_data) != exp_res) begin
      errors++;
      $display("FAIL result_t28 got valid=%b data=%0d want 1 %0d",
               v_log[28], bus.res_data, exp_res);
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || int'(bus.res_data) != exp_res || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall i=%0d got valid=%b data=%0d ready=%b want 1 %0d 0",
                 i, bus.res_valid, bus.res_data, bus.req_ready, exp_res);
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake got valid=%b ready=%b want 0 1",
               bus.res_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0;
    bus.req_fx = '0; bus.req_fy = '0; bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.rd_en !== 1'b0 ||
        bus.eng_cnt !== 3'd0 || bus.eng_x !== 24'd0 || bus.eng_p !== 8'd0 ||
        bus.res_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b rd_en=%b cnt=%0d x=%h p=%0d data=%0d",
               bus.req_ready, bus.res_valid, bus.rd_en, bus.eng_cnt, bus.eng_x,
               bus.eng_p, bus.res_data);
    end
    $display("reset: ready=%b valid=%b rd_en=%b cnt=%0d", bus.req_ready, bus.res_valid,
             bus.rd_en, bus.eng_cnt);
  endtask

  task automatic test_corner_low();
    int w;
    int tbl [16] = '{0, 0, 1, 2, 0, 0, 1, 2, 32, 32, 33, 34, 64, 64, 65, 66};
    fill_random();
    run_request(0, 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0, w);
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] != tbl[i]) begin
        errors++;
        $display("FAIL low_corner_addr #%0d got %0d want %0d", i, rd_q[i], tbl[i]);
      end
    end
  endtask

  task automatic test_corner_high();
    int w;
    int cols [4] = '{30, 31, 31, 31};
    fill_random();
    run_request(31, 31, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1, 0, w);
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] != cols[i/4] * W + cols[i%4]) begin
        errors++;
        $display("FAIL high_corner_addr #%0d got %0d want %0d", i, rd_q[i],
                 cols[i/4] * W + cols[i%4]);
      end
    end
  endtask

  task automatic test_eng_x();
    int w;
    fill_random();
    run_request(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 128, 0, 0, 0, w);
    checks++;
    if (x_log[1] !== 24'h804020 || x_log[20] !== 24'h804020 || x_log[21] !== 24'h000000) begin
      errors++;
      $display("FAIL eng_x_const got T1=%h T20=%h T21=%h want 804020 804020 000000",
               x_log[1], x_log[20], x_log[21]);
    end
  endtask

  task automatic test_constant();
    int w;
    fill_const(100);
    run_request(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, 0, 10, 0, w);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (p_log[22+r] !== 8'd99) begin
        errors++;
        $display("FAIL const_row%0d got %0d want 99", r, p_log[22+r]);
      end
    end
    checks++;
    if (v_log[28] !== 1'b1 || exp_res != 98) begin
      errors++;
      $display("FAIL const_result got valid=%b model=%0d want 1 98", v_log[28], exp_res);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    fill_random();
    run_request(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 12, w);
    run_request(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2, 0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    fill_random();
    for (int i = 0; i < 6; i++) begin
      run_request(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)), 0, w);
      if (i > 0) begin
        checks++;
        if (w != 0) begin
          errors++;
          $display("FAIL back_to_back #%0d got wait=%0d want 0", i, w);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_corner_low();
    test_corner_high();
    test_eng_x();
    test_constant();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
